// File: rtl/casl_pkg.sv
// casl_pkg: shared types, constants and the checksum helper for the
// CAS-Lock key-provisioning controller.
//   casl_state_e   controller state encoding
//   CASL_KEY_W_DEF default key width (bits)
//   CASL_CHK_W     checksum width (bits)
//   CASL_KEY_W_MAX widest key the checksum helper accepts
//   casl_xor_fold  byte-wise XOR of a key
package casl_pkg;

  localparam int CASL_KEY_W_DEF = 64;
  localparam int CASL_CHK_W     = 8;
  localparam int CASL_KEY_W_MAX = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_KEY,
    ST_LOAD_CHK,
    ST_VERIFY,
    ST_ARMED,
    ST_LOCKOUT
  } casl_state_e;

  // Callers zero-extend their key to CASL_KEY_W_MAX. Zero bytes do not
  // change an XOR, so one fixed-width helper serves every legal KEY_W.
  function automatic logic [CASL_CHK_W-1:0] casl_xor_fold(
    input logic [CASL_KEY_W_MAX-1:0] i_vec
  );
    logic [CASL_CHK_W-1:0] v_acc;
    v_acc = '0;
    for (int b = 0; b < CASL_KEY_W_MAX / CASL_CHK_W; b++) begin
      v_acc ^= i_vec[b*CASL_CHK_W +: CASL_CHK_W];
    end
    return v_acc;
  endfunction

endpackage

// File: rtl/casl_key_shreg.sv
// casl_key_shreg: bit-indexed capture register for the serial key and its
// checksum, plus the beat counter that addresses it. Bits arrive LSB
// first: key bits fill positions 0..KEY_W-1 and checksum bits follow.
//   clk, rst_n  clock, synchronous active-low reset
//   clr         clears the register and the counter
//   we          write bit_in at the current counter position, then advance
//   bit_in      serial data bit
//   key         captured key bits
//   chk         captured checksum bits
//   last_key    counter addresses the final key bit
//   last_chk    counter addresses the final checksum bit
module casl_key_shreg
  import casl_pkg::*;
#(
  parameter int KEY_W = CASL_KEY_W_DEF,
  parameter int CHK_W = CASL_CHK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic             bit_in,
  output logic [KEY_W-1:0] key,
  output logic [CHK_W-1:0] chk,
  output logic             last_key,
  output logic             last_chk
);

  localparam int TOT_W = KEY_W + CHK_W;
  localparam int CNT_W = $clog2(TOT_W + 1);

  logic [TOT_W-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: the data register is reset along with the counter; the key bus
  // must read back as zero after reset, never as stale key material.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (we) begin
      r_data[r_cnt] <= bit_in;
      r_cnt         <= r_cnt + 1'b1;
    end
  end

  assign key      = r_data[KEY_W-1:0];
  assign chk      = r_data[TOT_W-1:KEY_W];
  assign last_key = (r_cnt == CNT_W'(KEY_W - 1));
  assign last_chk = (r_cnt == CNT_W'(TOT_W - 1));

endmodule

// File: rtl/casl_key_ctrl.sv
// casl_key_ctrl: key-provisioning controller for a CAS-Lock-protected core.
// Loads a serial key and checksum, verifies the byte-wise XOR checksum,
// and only then drives the key bus and un-gates the core's output. Failed
// loads are counted; MAX_TRY failures lock the controller until reset.
//   clk, rst_n   clock, synchronous active-low reset
//   start        request a key load (sampled in IDLE)
//   zeroize      clear key, abort load (ignored in lockout)
//   key_sdata    serial key/checksum bit, LSB first
//   key_svalid   key_sdata valid
//   key_sready   controller accepts a bit this cycle
//   keyinput     key bus to the locked core, zero unless armed
//   lock_in      locked core's functional output
//   lock_out     gated functional output
//   armed        key verified and applied
//   busy         load in progress
//   err          one-cycle checksum mismatch pulse
//   lockout      sticky lockout flag
//   try_cnt      failed loads so far
module casl_key_ctrl
  import casl_pkg::*;
#(
  parameter int KEY_W   = CASL_KEY_W_DEF,
  parameter int CHK_W   = CASL_CHK_W,
  parameter int MAX_TRY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             zeroize,
  input  logic             key_sdata,
  input  logic             key_svalid,
  output logic             key_sready,
  output logic [KEY_W-1:0] keyinput,
  input  logic             lock_in,
  output logic             lock_out,
  output logic             armed,
  output logic             busy,
  output logic             err,
  output logic             lockout,
  output logic [3:0]       try_cnt
);

  casl_state_e r_state;
  casl_state_e w_next;
  logic [3:0]  r_try;

  logic             w_beat;
  logic             w_clr;
  logic             w_err;
  logic             w_try_inc;
  logic             w_zero;
  logic             w_match;
  logic             w_last_key;
  logic             w_last_chk;
  logic [3:0]       w_try_new;
  logic [KEY_W-1:0] w_key;
  logic [CHK_W-1:0] w_chk;

  casl_key_shreg #(
    .KEY_W (KEY_W),
    .CHK_W (CHK_W)
  ) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_clr),
    .we       (w_beat),
    .bit_in   (key_sdata),
    .key      (w_key),
    .chk      (w_chk),
    .last_key (w_last_key),
    .last_chk (w_last_chk)
  );

  // Lockout is absorbing, so zeroize has no effect there.
  assign w_zero    = zeroize && (r_state != ST_LOCKOUT);
  assign w_beat    = key_svalid && key_sready;
  assign w_match   = (casl_xor_fold(CASL_KEY_W_MAX'(w_key)) == w_chk);
  assign w_try_new = (r_try == 4'(MAX_TRY)) ? r_try : r_try + 4'd1;

  // NOTE: every signal written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    w_err     = 1'b0;
    w_try_inc = 1'b0;
    if (w_zero) begin
      w_next = ST_IDLE;
      w_clr  = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_next = ST_LOAD_KEY;
            w_clr  = 1'b1;
          end
        end
        ST_LOAD_KEY: if (w_beat && w_last_key) w_next = ST_LOAD_CHK;
        ST_LOAD_CHK: if (w_beat && w_last_chk) w_next = ST_VERIFY;
        ST_VERIFY: begin
          if (w_match) begin
            w_next = ST_ARMED;
          end else begin
            w_err     = 1'b1;
            w_clr     = 1'b1;
            w_try_inc = 1'b1;
            w_next    = (w_try_new == 4'(MAX_TRY)) ? ST_LOCKOUT : ST_IDLE;
          end
        end
        ST_ARMED:   w_next = ST_ARMED;
        ST_LOCKOUT: w_next = ST_LOCKOUT;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_try   <= '0;
    end else begin
      r_state <= w_next;
      if (w_try_inc) r_try <= w_try_new;
    end
  end

  // All outputs decode registered state (plus zeroize on the ready path),
  // so the key bus and gated output change only on the ARMED edges.
  assign armed      = (r_state == ST_ARMED);
  assign busy       = (r_state == ST_LOAD_KEY) || (r_state == ST_LOAD_CHK) ||
                      (r_state == ST_VERIFY);
  assign key_sready = ((r_state == ST_LOAD_KEY) || (r_state == ST_LOAD_CHK)) &&
                      !zeroize;
  assign lockout    = (r_state == ST_LOCKOUT);
  assign err        = w_err;
  assign try_cnt    = r_try;
  assign keyinput   = armed ? w_key : '0;
  assign lock_out   = armed && lock_in;

endmodule

// File: tb/tb_casl_key_ctrl.sv
// tb_casl_key_ctrl: scoreboard bench for casl_key_ctrl. The driver pushes
// the expected outcome of each load when it issues start; a monitor pops
// and compares whenever busy falls (the load has resolved).
module tb_casl_key_ctrl;

  localparam int KEY_W   = 64;
  localparam int MAX_TRY = 3;
  localparam logic [63:0] KEY_A = 64'hA5A5_0000_0000_00FF;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             zeroize;
  logic             key_sdata;
  logic             key_svalid;
  logic             key_sready;
  logic [KEY_W-1:0] keyinput;
  logic             lock_in;
  logic             lock_out;
  logic             armed;
  logic             busy;
  logic             err;
  logic             lockout;
  logic [3:0]       try_cnt;

  casl_key_ctrl #(.KEY_W(KEY_W), .CHK_W(8), .MAX_TRY(MAX_TRY)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .zeroize    (zeroize),
    .key_sdata  (key_sdata),
    .key_svalid (key_svalid),
    .key_sready (key_sready),
    .keyinput   (keyinput),
    .lock_in    (lock_in),
    .lock_out   (lock_out),
    .armed      (armed),
    .busy       (busy),
    .err        (err),
    .lockout    (lockout),
    .try_cnt    (try_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        armed;
    logic [63:0] key;
    logic [3:0]  tries;
    logic        lockout;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   m_try  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_fold(input logic [63:0] k);
    logic [7:0] x;
    x = 8'h00;
    for (int b = 0; b < 8; b++) x ^= 8'((k >> (8 * b)) & 64'hFF);
    return x;
  endfunction

  // Monitor: a load has resolved when busy drops.
  initial begin
    logic prev_busy;
    logic err_seen;
    exp_t e;
    prev_busy = 1'b0;
    err_seen  = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && err === 1'b1) err_seen = 1'b1;
      if (prev_busy === 1'b1 && busy === 1'b0) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("res_armed",   64'(armed),    64'(e.armed));
          check("res_key",     keyinput,      e.key);
          check("res_try_cnt", 64'(try_cnt),  64'(e.tries));
          check("res_lockout", 64'(lockout),  64'(e.lockout));
          check("res_err",     64'(err_seen), 64'(e.err));
        end
        err_seen = 1'b0;
      end
      prev_busy = busy;
    end
  end

  // One load. abort_kind: 0 none, 1 zeroize, 2 reset, applied when bit
  // abort_idx is presented (72 = the verify cycle, zeroize only).
  // vmode: 0 valid held high, 1 valid 1-0-1-0 from the start cycle, 2 random.
  // Entered and left at #1 after a rising edge.
  task automatic run_load(input logic [63:0] key, input logic [7:0] chk,
                          input int vmode, input int abort_kind,
                          input int abort_idx, input int exp_verify_rel);
    logic [71:0] stream;
    exp_t        e;
    int          idx;
    int          c0;
    int          budget;
    bit          aborted;
    stream  = {chk, key};
    idx     = 0;
    budget  = 0;
    aborted = 1'b0;
    if (abort_kind == 1) begin
      e = '{armed: 1'b0, key: 64'd0, tries: 4'(m_try), lockout: 1'b0, err: 1'b0};
    end else if (abort_kind == 2) begin
      m_try = 0;
      e = '{armed: 1'b0, key: 64'd0, tries: 4'd0, lockout: 1'b0, err: 1'b0};
    end else if (ref_fold(key) == chk) begin
      e = '{armed: 1'b1, key: key, tries: 4'(m_try), lockout: 1'b0, err: 1'b0};
    end else begin
      if (m_try < MAX_TRY) m_try++;
      e = '{armed: 1'b0, key: 64'd0, tries: 4'(m_try),
            lockout: (m_try == MAX_TRY), err: 1'b1};
    end
    sb_q.push_back(e);

    start      = 1'b1;
    key_svalid = 1'b1;
    c0         = cyc;
    @(posedge clk); #1;
    start = 1'b0;

    while (idx < 72 && budget < 2000) begin
      key_sdata = stream[idx];
      case (vmode)
        0:       key_svalid = 1'b1;
        1:       key_svalid = ((cyc - c0) % 2 == 0);
        default: key_svalid = 1'($urandom_range(0, 1));
      endcase
      if (abort_kind == 1 && idx == abort_idx) zeroize = 1'b1;
      if (abort_kind == 2 && idx == abort_idx) rst_n = 1'b0;
      @(negedge clk);
      if (zeroize) begin
        check("sready_zeroize", 64'(key_sready), 64'd0);
        aborted = 1'b1;
      end else if (!rst_n) begin
        aborted = 1'b1;
      end else begin
        check("sready_load", 64'(key_sready), 64'd1);
        if (key_svalid && key_sready) idx++;
      end
      @(posedge clk); #1;
      budget++;
      if (aborted) break;
    end

    key_svalid = 1'b0;
    if (aborted) begin
      zeroize = 1'b0;
      rst_n   = 1'b1;
      @(negedge clk);
      check("abort_busy",    64'(busy),     64'd0);
      check("abort_sready",  64'(key_sready), 64'd0);
      check("abort_key",     keyinput,      64'd0);
      check("abort_armed",   64'(armed),    64'd0);
      check("abort_try_cnt", 64'(try_cnt),  64'(m_try));
      check("abort_lockout", 64'(lockout),  64'd0);
      check("abort_err",     64'(err),      64'd0);
      @(posedge clk); #1;
      return;
    end
    if (idx < 72) begin
      check("load_budget", 64'(idx), 64'd72);
      return;
    end

    // Verify cycle.
    if (abort_kind == 1 && abort_idx == 72) zeroize = 1'b1;
    @(negedge clk);
    check("verify_busy",  64'(busy),  64'd1);
    check("verify_armed", 64'(armed), 64'd0);
    check("verify_key",   keyinput,   64'd0);
    check("verify_err",   64'(err),   64'(e.err));
    if (exp_verify_rel > 0)
      check("verify_cycle", 64'(cyc - c0), 64'(exp_verify_rel));
    @(posedge clk); #1;
    zeroize = 1'b0;
  endtask

  task automatic disarm();
    lock_in = 1'b1;
    zeroize = 1'b1;
    @(negedge clk);
    check("disarm_still_armed", 64'(armed), 64'd1);
    @(posedge clk); #1;
    zeroize = 1'b0;
    @(negedge clk);
    check("disarm_armed",    64'(armed),    64'd0);
    check("disarm_key",      keyinput,      64'd0);
    check("disarm_lock_out", 64'(lock_out), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_try = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rkey;
    logic [7:0]  rchk;
    int          ak;
    int          ai;
    rst_n      = 1'b0;
    start      = 1'b0;
    zeroize    = 1'b0;
    key_sdata  = 1'b0;
    key_svalid = 1'b0;
    lock_in    = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check("rst_sready",   64'(key_sready), 64'd0);
    check("rst_key",      keyinput,        64'd0);
    check("rst_lock_out", 64'(lock_out),   64'd0);
    check("rst_armed",    64'(armed),      64'd0);
    check("rst_busy",     64'(busy),       64'd0);
    check("rst_err",      64'(err),        64'd0);
    check("rst_lockout",  64'(lockout),    64'd0);
    check("rst_try_cnt",  64'(try_cnt),    64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Correct key, valid held high: arms at cycle 74, output follows lock_in.
    run_load(KEY_A, 8'hFF, 0, 0, 0, 73);
    @(negedge clk);
    check("t1_armed", 64'(armed), 64'd1);
    check("t1_key",   keyinput,   KEY_A);
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lock_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("t1_lock_out", 64'(lock_out), 64'(lock_in));
      check("t1_start_ignored", 64'(busy), 64'd0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    disarm();

    // Three bad checksums back to back, then lockout.
    run_load(KEY_A, 8'h00, 0, 0, 0, 73);
    run_load(KEY_A, 8'h00, 0, 0, 0, 73);
    run_load(KEY_A, 8'h00, 0, 0, 0, 73);
    @(negedge clk);
    check("t2_lockout", 64'(lockout), 64'd1);
    check("t2_try_cnt", 64'(try_cnt), 64'd3);
    @(posedge clk); #1;
    start      = 1'b1;
    zeroize    = 1'b1;
    key_svalid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t2_locked_busy",   64'(busy),       64'd0);
      check("t2_locked_sready", 64'(key_sready), 64'd0);
      check("t2_locked_key",    keyinput,        64'd0);
      check("t2_locked_flag",   64'(lockout),    64'd1);
      @(posedge clk); #1;
    end
    start      = 1'b0;
    zeroize    = 1'b0;
    key_svalid = 1'b0;
    do_reset();
    @(negedge clk);
    check("t2_reset_lockout", 64'(lockout), 64'd0);
    check("t2_reset_try_cnt", 64'(try_cnt), 64'd0);
    @(posedge clk); #1;

    // One failure, then zeroize at key bit 30, then a clean reload.
    run_load(KEY_A, 8'h5A, 0, 0, 0, 73);
    run_load(KEY_A, 8'hFF, 0, 1, 30, 0);
    run_load(KEY_A, 8'hFF, 0, 0, 0, 73);
    disarm();

    // valid toggling 1-0-1-0: verify at cycle 145, arm at 146.
    run_load(KEY_A, 8'hFF, 1, 0, 0, 145);
    disarm();

    // Reset during the checksum phase, then a clean load.
    run_load(KEY_A, 8'hFF, 0, 2, 66, 0);
    run_load(KEY_A, 8'hFF, 0, 0, 0, 73);
    disarm();

    // Zeroize with the final checksum beat; zeroize with a verify mismatch.
    run_load(KEY_A, 8'hFF, 0, 1, 71, 0);
    run_load(KEY_A, 8'h00, 0, 1, 72, 0);
    // start together with zeroize in IDLE stays in IDLE.
    start   = 1'b1;
    zeroize = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    zeroize = 1'b0;
    @(negedge clk);
    check("idle_start_zeroize_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // Randomized loads against the model.
    for (int n = 0; n < 30; n++) begin
      rkey = {$urandom, $urandom};
      rchk = ($urandom_range(0, 1) == 1) ? ref_fold(rkey) : 8'($urandom);
      ak   = ($urandom_range(0, 4) == 0) ? 1 : 0;
      ai   = $urandom_range(0, 72);
      run_load(rkey, rchk, ($urandom_range(0, 1) == 1) ? 2 : 0, ak, ai, 0);
      if (ak == 0 && ref_fold(rkey) == rchk) disarm();
      else if (m_try == MAX_TRY) do_reset();
    end

    repeat (3) @(posedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
